// File: rtl/spi_mode0_rx.sv
// SPI mode-0 slave receiver: oversamples SCLK/MOSI/CS, assembles MSB-first words
// and hands them to the local consumer through a small first-word-fall-through FIFO.
`timescale 1ns/1ps
module spi_mode0_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SCLK,
    input  logic              MOSI,
    input  logic              CS,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overflow,
    output logic              busy
);
    localparam int BIT_W = $clog2(DATA_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic [SYNC_STAGES-1:0] cs_sync_reg;
    logic                   sclk_prev_reg;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   cs_s;
    logic                   sclk_rise;

    state_t                 state_reg;
    state_t                 state_next;
    logic [DATA_W-2:0]      shift_reg;
    logic [DATA_W-2:0]      shift_next;
    logic [BIT_W-1:0]       bit_cnt_reg;
    logic [BIT_W-1:0]       bit_cnt_next;
    logic                   frame_err_reg;
    logic                   frame_err_next;
    logic                   overflow_reg;
    logic                   overflow_next;
    logic                   push;
    logic [DATA_W-1:0]      push_word;

    logic [DATA_W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [CNT_W-1:0]       count_reg;
    logic                   full;
    logic                   pop;
    logic                   wr_en;

    // All three lines share one chain depth so MOSI stays aligned with its SCLK edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_reg <= '0;
            mosi_sync_reg <= '0;
            cs_sync_reg   <= '1;
            sclk_prev_reg <= 1'b0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], SCLK};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], MOSI};
            cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], CS};
            sclk_prev_reg <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
    assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_reg;

    // Only DATA_W-1 bits are held: the final bit joins the word as it is pushed.
    assign push_word = {shift_reg, mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            frame_err_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            bit_cnt_reg   <= bit_cnt_next;
            frame_err_reg <= frame_err_next;
            overflow_reg  <= overflow_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        bit_cnt_next   = bit_cnt_reg;
        frame_err_next = 1'b0;
        push           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!cs_s) begin
                    state_next   = SHIFT;
                    shift_next   = '0;
                    bit_cnt_next = '0;
                end
            end
            SHIFT: begin
                // CS release takes priority over a coincident SCLK edge.
                if (cs_s) begin
                    state_next     = IDLE;
                    bit_cnt_next   = '0;
                    frame_err_next = (bit_cnt_reg != '0);
                end else if (sclk_rise) begin
                    shift_next = push_word[DATA_W-2:0];
                    if (bit_cnt_reg == BIT_W'(DATA_W - 1)) begin
                        push         = 1'b1;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state_reg == SHIFT);
    assign frame_err = frame_err_reg;
    assign overflow  = overflow_reg;

    assign rx_valid      = (count_reg != '0);
    assign full          = (count_reg == CNT_W'(FIFO_DEPTH));
    assign pop           = rx_valid & rx_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign wr_en         = push & (~full | pop);
    assign overflow_next = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= push_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Gate the head so an empty FIFO presents zero rather than stale storage.
    assign rx_data = rx_valid ? mem[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_spi_mode0_rx.sv
// Bench for spi_mode0_rx: directed scenarios plus random frames scored against
// a bit-stream model of what an SPI mode-0 master delivers.
`timescale 1ns/1ps
module tb_spi_mode0_rx;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       SCLK;
    logic       MOSI;
    logic       CS;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overflow;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic       rand_ready = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    spi_mode0_rx #(.DATA_W(8), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .MOSI(MOSI), .CS(CS),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overflow(overflow), .busy(busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rand_ready) rx_ready = ($urandom_range(0, 1) == 1);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) begin
                got_q.push_back(rx_data);
                $display("rx word %02h", rx_data);
            end
            if (frame_err) fe_cnt++;
            if (overflow) ov_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #2;
        rx_ready = v;
    endtask

    task automatic spi_bit(input logic b);
        @(negedge clk);
        MOSI = b;
        repeat (24) @(negedge clk);
        SCLK = 1'b1;
        repeat (25) @(negedge clk);
        SCLK = 1'b0;
    endtask

    // Raise SCLK for bit b and return in the cycle the push is being presented.
    task automatic last_bit_until_push(input logic b);
        @(negedge clk);
        MOSI = b;
        repeat (24) @(negedge clk);
        SCLK = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic finish_bit;
        repeat (24) @(negedge clk);
        SCLK = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) spi_bit(v[i]);
    endtask

    task automatic cs_begin;
        @(negedge clk);
        CS = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    task automatic cs_end;
        repeat (25) @(negedge clk);
        CS = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic clear_sb;
        got_q.delete();
        exp_q.delete();
        fe_cnt = 0;
        ov_cnt = 0;
    endtask

    task automatic wait_words(input int n);
        int t = 0;
        while (got_q.size() < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic compare_words(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] burst [4];
        rst_n = 1'b0; SCLK = 1'b0; MOSI = 1'b0; CS = 1'b1; rx_ready = 1'b0;
        burst[0] = 8'h01; burst[1] = 8'h80; burst[2] = 8'hFF; burst[3] = 8'h3C;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte with push latency
        clear_sb();
        cs_begin();
        check("single_busy", busy, 1);
        for (int i = 7; i >= 1; i--) spi_bit(1'((8'hA5 >> i) & 8'h01));
        last_bit_until_push(1'b1);
        check("single_pre_valid", rx_valid, 0);
        @(posedge clk);
        #1;
        check("single_valid", rx_valid, 1);
        check("single_data", rx_data, 8'hA5);
        finish_bit();
        cs_end();
        check("single_idle", busy, 0);
        set_ready(1'b1);
        exp_q.push_back(8'hA5);
        wait_words(1);
        compare_words("single");
        check("single_ferr", fe_cnt, 0);

        // Burst in one frame
        clear_sb();
        cs_begin();
        for (int i = 0; i < 4; i++) begin
            spi_byte(burst[i]);
            exp_q.push_back(burst[i]);
        end
        cs_end();
        wait_words(4);
        compare_words("burst");
        check("burst_ovf", ov_cnt, 0);

        // Overflow: fifth word dropped
        set_ready(1'b0);
        clear_sb();
        cs_begin();
        for (int i = 0; i < 5; i++) spi_byte(8'(8'h10 + i));
        cs_end();
        check("ovf_pulses", ov_cnt, 1);
        check("ovf_head", rx_data, 8'h10);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'h10 + i));
        set_ready(1'b1);
        wait_words(4);
        compare_words("ovf");

        // Full FIFO with push and pop in the same cycle
        set_ready(1'b0);
        clear_sb();
        cs_begin();
        for (int i = 0; i < 4; i++) spi_byte(8'(8'h10 + i));
        for (int i = 7; i >= 1; i--) spi_bit(1'((8'h14 >> i) & 8'h01));
        last_bit_until_push(1'b0);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        check("pp_head", rx_data, 8'h11);
        finish_bit();
        cs_end();
        check("pp_ovf", ov_cnt, 0);
        for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h10 + i));
        set_ready(1'b1);
        wait_words(5);
        compare_words("pp");

        // Abort after three bits, then a clean frame
        clear_sb();
        cs_begin();
        for (int i = 0; i < 3; i++) spi_bit(1'b1);
        cs_end();
        check("abort_ferr", fe_cnt, 1);
        check("abort_nopush", got_q.size(), 0);
        cs_begin();
        spi_byte(8'h5A);
        cs_end();
        exp_q.push_back(8'h5A);
        wait_words(1);
        compare_words("abort");
        check("abort_ferr_total", fe_cnt, 1);

        // Reset mid-word, then SCLK activity with CS high
        set_ready(1'b0);
        clear_sb();
        cs_begin();
        spi_byte(8'h77);
        for (int i = 0; i < 4; i++) spi_bit(1'b1);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mrst_valid", rx_valid, 0);
        check("mrst_data", rx_data, 0);
        check("mrst_busy", busy, 0);
        check("mrst_ferr", frame_err, 0);
        check("mrst_ovf", overflow, 0);
        CS = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) spi_bit(($urandom & 1) != 0);
        repeat (10) @(negedge clk);
        check("csh_busy", busy, 0);
        check("csh_valid", rx_valid, 0);
        check("csh_ferr", fe_cnt, 0);

        // Random frames against the bit-stream model
        clear_sb();
        begin
            int exp_fe = 0;
            @(posedge clk);
            rand_ready = 1'b1;
            for (int f = 0; f < 10; f++) begin
                int   nbits = int'($urandom_range(1, 32));
                logic bits[$];
                for (int k = 0; k < nbits; k++) bits.push_back(($urandom & 1) != 0);
                for (int w = 0; w < nbits / 8; w++) begin
                    int word = 0;
                    for (int k = 0; k < 8; k++) word = word * 2 + (bits[w * 8 + k] ? 1 : 0);
                    exp_q.push_back(8'(word));
                end
                if (nbits % 8 != 0) exp_fe++;
                cs_begin();
                for (int k = 0; k < nbits; k++) spi_bit(bits[k]);
                cs_end();
            end
            @(negedge clk);
            rand_ready = 1'b0;
            set_ready(1'b1);
            wait_words(exp_q.size());
            compare_words("rand");
            check("rand_ferr", fe_cnt, exp_fe);
            check("rand_ovf", ov_cnt, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
